demux_deser: RTL and testbench

Serial-to-parallel demultiplexer: the receive-side inverse of the 8:1 bit-select mux. It steers a stream of single bits into successive slots of a WIDTH-bit word, using an internal slot counter as the select. It presents each completed word on a valid/ready output with one word of buffering. It sits at the receiving end of any link that serialises words through a bit-select mux.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_slot_ctr.sv | 29 ++
 rtl/demux_deser.sv | 77 +++++++
 tb/tb_demux_deser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and bit-order mapping for the serial-to-parallel demux.
// Define DEMUX_DESER_MSB_FIRST_EN to fill words MSB-first instead of LSB-first.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SEL_W = $clog2(DEF_WIDTH);

  // Map the slot counter value to the shadow bit it fills.
  function automatic int unsigned slot_of(input int unsigned sel, input int unsigned width);
`ifdef DEMUX_DESER_MSB_FIRST_EN
    return width - 1 - sel;
`else
    return sel + (width - width);
`endif
  endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Wrapping slot counter: selects the next shadow slot and flags the final slot.
module demux_slot_ctr
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  assign last = (sel == SEL_W'(WIDTH - 1));

  // clr has priority so an abort always restarts the word at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (clr) begin
      sel <= '0;
    end else if (inc) begin
      sel <= last ? '0 : sel + SEL_W'(1);
    end
  end

endmodule

// File: rtl/demux_deser.sv
// Serial-to-parallel demux: steers accepted bits into a shadow word and hands
// completed words out on a one-deep valid/ready register.
// Bit order set by DEMUX_DESER_MSB_FIRST_EN (undefined: LSB-first).
module demux_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             bit_rdy,
  input  logic             clr,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] merged;
  logic [SEL_W-1:0] slot_idx;
  logic             last;
  logic             accept;
  logic             complete;
  logic             drain;

  demux_slot_ctr #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (clr),
    .sel   (sel),
    .last  (last)
  );

  // The final bit waits only if the output register is full and not draining
  assign bit_rdy  = !(last && out_vld && !out_rdy);
  assign accept   = bit_vld && bit_rdy && !clr;
  assign complete = accept && last;
  assign drain    = out_vld && out_rdy;
  assign slot_idx = SEL_W'(slot_of(32'(sel), WIDTH));

  always_comb begin
    merged           = shadow;
    merged[slot_idx] = bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (clr || complete) begin
      shadow <= '0;
    end else if (accept) begin
      shadow <= merged;
    end
  end

  // A completion in the same cycle as a drain reloads and keeps out_vld high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      out_vld <= 1'b0;
    end else if (complete) begin
      out     <= merged;
      out_vld <= 1'b1;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: directed scenarios plus random traffic
// against a queue-based word-assembly model.
module tb_demux_deser;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_in;
  logic          bit_vld;
  logic          bit_rdy;
  logic          clr;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_w;
  logic          out_vld;
  logic          out_rdy;

  int nchk  = 0;
  int nfail = 0;

  bit         m_q[$];
  logic [W-1:0] m_out;
  logic       m_vld;

  demux_deser #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .bit_rdy (bit_rdy),
    .clr     (clr),
    .sel     (sel),
    .out     (out_w),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position within the word of the i-th transmitted bit.
  function automatic int unsigned pos_of(input int unsigned i);
`ifdef DEMUX_DESER_MSB_FIRST_EN
    return W - 1 - i;
`else
    return i;
`endif
  endfunction

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w = '0;
    for (int i = 0; i < int'(W); i++) w[pos_of(i)] = m_q[i];
    return w;
  endfunction

  function automatic logic exp_rdy();
    return !(m_q.size() == int'(W) - 1 && m_vld && !out_rdy);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out = '0;
    m_vld = 1'b0;
  endtask

  task automatic drive(input logic v, input logic b, input logic c, input logic r);
    bit_vld = v;
    bit_in  = b;
    clr     = c;
    out_rdy = r;
  endtask

  // Compare against the model, clock once, then advance the model.
  task automatic tick();
    logic acc;
    #1;
    chk("sel", int'(sel), m_q.size());
    chk("out_vld", int'(out_vld), int'(m_vld));
    chk("out", int'(out_w), int'(m_out));
    chk("bit_rdy", int'(bit_rdy), int'(exp_rdy()));
    acc = bit_vld && exp_rdy() && !clr;
    @(posedge clk);
    if (m_vld && out_rdy) m_vld = 1'b0;
    if (clr) begin
      m_q.delete();
    end else if (acc) begin
      m_q.push_back(bit_in);
      if (m_q.size() == int'(W)) begin
        m_out = assemble();
        m_vld = 1'b1;
        m_q.delete();
      end
    end
    @(negedge clk);
  endtask

  // Send count bits of word in transmission order, retrying a refused bit.
  task automatic send(input logic [W-1:0] word, input int count, input logic r);
    for (int i = 0; i < count; i++) begin
      int tries = 0;
      drive(1'b1, word[pos_of(i)], 1'b0, r);
      while (!exp_rdy() && tries < 20) begin
        tick();
        tries++;
      end
      if (tries >= 20) chk("send_timeout", 1, 0);
      tick();
    end
  endtask

  initial begin
    logic [W-1:0] stream[4];
    bit           lsb_bits[W];
    stream = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
`ifdef DEMUX_DESER_MSB_FIRST_EN
    lsb_bits = '{1, 0, 1, 0, 1, 0, 1, 1};
`else
    lsb_bits = '{1, 1, 0, 1, 0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    #12;
    chk("rst_sel", int'(sel), 0);
    chk("rst_out", int'(out_w), 0);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_bit_rdy", int'(bit_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed word 8'hAB with the hand-written bit sequence
    for (int i = 0; i < int'(W); i++) begin
      drive(1'b1, lsb_bits[i], 1'b0, 1'b1);
      #1 chk("ab_sel_step", int'(sel), i);
      tick();
    end
    chk("ab_out", int'(out_w), 8'hAB);
    chk("ab_vld", int'(out_vld), 1);
    chk("ab_sel_wrap", int'(sel), 0);

    // Backpressure: hold 8'hAB, fill 7 bits of 8'h3C, final bit stalls
    send(8'h3C, 7, 1'b0);
    chk("bp_sel7", int'(sel), 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("bp_rdy_low", int'(bit_rdy), 0);
    tick();
    tick();
    chk("bp_out_held", int'(out_w), 8'hAB);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("bp_rdy_high", int'(bit_rdy), 1);
    tick();
    chk("bp_out_next", int'(out_w), 8'h3C);
    chk("bp_vld_stays", int'(out_vld), 1);

    // clr at sel=4 with a bit presented; pending word untouched
    send(8'hFF, 4, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("clr_sel", int'(sel), 0);
    chk("clr_out_kept", int'(out_w), 8'h3C);
    chk("clr_vld_kept", int'(out_vld), 1);
    send(8'h96, 8, 1'b1);
    chk("clr_clean_word", int'(out_w), 8'h96);

    // Async reset at sel=5 with a pending word
    send(8'h11, 5, 1'b0);
    chk("ar_pre_vld", int'(out_vld), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", int'(sel), 0);
    chk("ar_out", int'(out_w), 0);
    chk("ar_vld", int'(out_vld), 0);
    chk("ar_rdy", int'(bit_rdy), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hE7, 8, 1'b1);
    chk("ar_first_word", int'(out_w), 8'hE7);

    // Four back-to-back words, no bubble
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(W); i++) begin
        drive(1'b1, stream[k][pos_of(i)], 1'b0, 1'b1);
        #1 chk("stream_rdy", int'(bit_rdy), 1);
        tick();
      end
      chk("stream_word", int'(out_w), int'(stream[k]));
      chk("stream_vld", int'(out_vld), 1);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
